// File: rtl/fb_readout_pkg.sv
// fb_readout_pkg: shared types for the frame-buffer readout path.
// Provides the 24-bit pixel type, the readout FSM state encoding
// (plain localparam constants so older tools can consume them), the
// default frame geometry, and the RGB565 packing helper.
package fb_readout_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_HEIGHT = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  typedef logic [1:0] fb_rd_state_t;

  localparam fb_rd_state_t ST_IDLE  = 2'd0;
  localparam fb_rd_state_t ST_RUN   = 2'd1;
  localparam fb_rd_state_t ST_DRAIN = 2'd2;
  localparam fb_rd_state_t ST_DONE  = 2'd3;

  function automatic logic [15:0] to_rgb565(input color_t c);
    return {c.r[7:3], c.g[7:2], c.b[7:3]};
  endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// fb_skid_fifo: small circular FIFO of color_t entries.
// Ports:
//   clk, n_rst          clock, async active-low reset (empties the FIFO)
//   push, push_data     write one entry at the tail
//   pop, pop_two        remove one entry, or two when pop_two is also set
//   head, head_next     the oldest and second-oldest entries
//   count               current number of entries
// The caller guarantees it never pushes into a full FIFO and never pops
// more entries than count holds.
module fb_skid_fifo
  import fb_readout_pkg::*;
#(
  parameter int DEPTH = 3
)(
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         push,
  input  color_t                       push_data,
  input  logic                         pop,
  input  logic                         pop_two,
  output color_t                       head,
  output color_t                       head_next,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  color_t        store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] pop_num;

  // Pointer wrap for a depth that need not be a power of two.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p, input int n);
    int t;
    t = int'(p) + n;
    if (t >= DEPTH) t = t - DEPTH;
    return PW'(t);
  endfunction

  assign pop_num   = !pop ? CW'(0) : (pop_two ? CW'(2) : CW'(1));
  assign head      = store[rd_ptr];
  assign head_next = store[advance(rd_ptr, 1)];

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= advance(wr_ptr, 1);
      if (pop)  rd_ptr <= advance(rd_ptr, int'(pop_num));
      count <= count + CW'(push) - pop_num;
    end
  end

endmodule

// File: rtl/fb_readout.sv
// fb_readout: walks a rectangular window of the frame buffer in raster
// order, issues pipelined reads and streams pixels to the host as 32-bit
// words under a valid/ready handshake.
// Ports:
//   clk, n_rst                 clock, async active-low reset
//   start                      launch pulse, accepted only in IDLE
//   x0, x1, y0, y1             inclusive window bounds (x1/y1 clamped)
//   mode                       0: {8'h00,r,g,b} per word; 1: two RGB565 pixels
//   mem_re, mem_addr           read strobe and address y*WIDTH+x
//   mem_rdata                  read data, READ_LAT cycles after mem_re
//   data_valid, ready_for_data, data_out   host stream
//   busy                       high in RUN and DRAIN
//   transfer_done              one-cycle pulse (DONE state)
module fb_readout
  import fb_readout_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int ADDR_W     = $clog2(WIDTH * HEIGHT),
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = READ_LAT + 2,
  localparam int XW        = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
)(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [XW-1:0]     x0,
  input  logic [XW-1:0]     x1,
  input  logic [YW-1:0]     y0,
  input  logic [YW-1:0]     y1,
  input  logic              mode,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  color_t            mem_rdata,
  output logic              data_valid,
  input  logic              ready_for_data,
  output logic [31:0]       data_out,
  output logic              busy,
  output logic              transfer_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fb_rd_state_t        state;
  logic [XW-1:0]       x0_l, x1_l, x_cnt, x1_c;
  logic [YW-1:0]       y1_l, y_cnt, y1_c;
  logic                mode_l;
  logic [ADDR_W-1:0]   row_base;
  logic [READ_LAT-1:0] vld_pipe;
  logic [CW-1:0]       fifo_count;
  color_t              head, head_next;
  logic [7:0]          inflight, pop_num;
  logic                win_empty, active, pair_full, drained;
  logic                beat, pop_two, credit, last_addr;

  assign x1_c      = (x1 > XW'(WIDTH - 1))  ? XW'(WIDTH - 1)  : x1;
  assign y1_c      = (y1 > YW'(HEIGHT - 1)) ? YW'(HEIGHT - 1) : y1;
  assign win_empty = (x0 > x1_c) || (y0 > y1_c);

  // Reads issued whose data has not yet been pushed into the FIFO,
  // including the one landing on mem_rdata this cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + 8'(vld_pipe[i]);
  end

  assign active    = (state == ST_RUN) || (state == ST_DRAIN);
  assign pair_full = fifo_count >= CW'(2);
  assign drained   = (state == ST_DRAIN) && (inflight == 8'd0);

  // In mode 1 a lone pixel is only emitted once every read has returned,
  // which means it is the odd final pixel of the window.
  always_comb begin
    data_valid = 1'b0;
    if (active) begin
      if (!mode_l) data_valid = (fifo_count != '0);
      else         data_valid = pair_full || ((fifo_count == CW'(1)) && drained);
    end
  end

  always_comb begin
    data_out = 32'h0;
    if (data_valid) begin
      if (!mode_l) data_out = {8'h00, head};
      else         data_out = {pair_full ? to_rgb565(head_next) : 16'h0, to_rgb565(head)};
    end
  end

  assign beat    = data_valid && ready_for_data;
  assign pop_two = mode_l && pair_full;
  assign pop_num = !beat ? 8'd0 : (pop_two ? 8'd2 : 8'd1);

  // Credit check: slots freed by this cycle's pop are reusable because a
  // read issued now lands at least one edge later. This keeps mode 1 at
  // one read per cycle without ever overfilling the FIFO.
  assign credit    = (8'(fifo_count) + inflight - pop_num) < 8'(FIFO_DEPTH);
  assign mem_re    = (state == ST_RUN) && credit;
  assign mem_addr  = row_base + ADDR_W'(x_cnt);
  assign last_addr = (x_cnt == x1_l) && (y_cnt == y1_l);

  assign busy          = active;
  assign transfer_done = (state == ST_DONE);

  fb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (vld_pipe[READ_LAT-1]),
    .push_data (mem_rdata),
    .pop       (beat),
    .pop_two   (pop_two),
    .head      (head),
    .head_next (head_next),
    .count     (fifo_count)
  );

  // Read-valid pipeline; cleared by reset so late data after an abort is
  // never pushed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= mem_re;
      for (int i = 1; i < READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // FSM and address walker. The starting row base is a constant-coefficient
  // product; per-pixel addresses only ever add WIDTH or step x.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      x0_l     <= '0;
      x1_l     <= '0;
      y1_l     <= '0;
      mode_l   <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      row_base <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x0_l     <= x0;
            x1_l     <= x1_c;
            y1_l     <= y1_c;
            mode_l   <= mode;
            x_cnt    <= x0;
            y_cnt    <= y0;
            row_base <= ADDR_W'(y0 * WIDTH);
            state    <= win_empty ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (mem_re) begin
            if (last_addr) begin
              state <= ST_DRAIN;
            end else if (x_cnt == x1_l) begin
              x_cnt    <= x0_l;
              y_cnt    <= y_cnt + YW'(1);
              row_base <= row_base + ADDR_W'(WIDTH);
            end else begin
              x_cnt <= x_cnt + XW'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Leave once nothing is in flight and this cycle's beat (if any)
          // takes everything left in the FIFO.
          if ((inflight == 8'd0) && (8'(fifo_count) == pop_num)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
